// File: rtl/alu_pipe.sv
// Pipelined ALU. Stage 1 captures an accepted op. The next enabled edge writes the result and flags.
// MUL instead runs a WIDTH-edge shift-add loop while the input is stalled.
module alu_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             OE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    output wire  [WIDTH-1:0] ALU_OUT,
    output logic             CF,
    output logic             OF,
    output logic             SF,
    output logic             ZF,
    output logic             BUSY
);
    localparam int CNT_W = SHW + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;
    localparam logic [3:0] OP_ADC = 4'b0001, OP_SBB = 4'b0010, OP_ADD = 4'b0011,
                           OP_SUB = 4'b0100, OP_AND = 4'b0101, OP_OR  = 4'b0110,
                           OP_XOR = 4'b0111, OP_NOT = 4'b1000, OP_SHL = 4'b1001,
                           OP_SHR = 4'b1010, OP_SAR = 4'b1011, OP_MUL = 4'b1100,
                           OP_CMP = 4'b1101;

    logic               s1_valid_q, s1_valid_d;
    logic [3:0]         s1_op_q, s1_op_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [0:0]         state_q, state_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic               cf_q, cf_d, of_q, of_d, sf_q, sf_d, zf_q, zf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept_s, in_ready_s, cin_s, upd_s, wr_s;
    logic               cf_s, of_s, sf_s, zf_s;
    logic [WIDTH-1:0]   res_s;
    logic [WIDTH:0]     sum_s, diff_s;
    logic [2*WIDTH-1:0] shl_s, shr_s, sar_s, acc_nx_s;
    logic [SHW-1:0]     amt_s;

    // A MUL waiting in stage 1 also withholds ready, so no op can be accepted on its compute edge.
    always_comb begin
        in_ready_s = ~busy_q & ~(s1_valid_q & (s1_op_q == OP_MUL));
        accept_s   = EN & IN_VALID & in_ready_s;
    end

    // Single-cycle datapath on the stage-1 operands, plus one multiplier shift-add step.
    always_comb begin
        if ((s1_op_q == OP_ADC) || (s1_op_q == OP_SBB)) begin
            cin_s = cf_q;
        end else begin
            cin_s = 1'b0;
        end
        amt_s    = s1_b_q[SHW-1:0];
        sum_s    = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, cin_s};
        diff_s   = {1'b0, s1_a_q} - {1'b0, s1_b_q} - {{WIDTH{1'b0}}, cin_s};
        shl_s    = {{WIDTH{1'b0}}, s1_a_q} << amt_s;
        shr_s    = {s1_a_q, {WIDTH{1'b0}}} >> amt_s;
        sar_s    = $signed({s1_a_q, {WIDTH{1'b0}}}) >>> amt_s;
        acc_nx_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        res_s    = alu_out_q;
        cf_s     = cf_q;
        of_s     = of_q;
        upd_s    = 1'b1;
        wr_s     = 1'b1;
        case (s1_op_q)
            OP_ADC, OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                cf_s  = sum_s[WIDTH];
                of_s  = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum_s[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SBB, OP_SUB, OP_CMP: begin
                res_s = diff_s[WIDTH-1:0];
                cf_s  = diff_s[WIDTH];
                of_s  = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff_s[WIDTH-1] != s1_a_q[WIDTH-1]);
                wr_s  = (s1_op_q != OP_CMP);
            end
            OP_AND: begin res_s = s1_a_q & s1_b_q; cf_s = 1'b0; of_s = 1'b0; end
            OP_OR:  begin res_s = s1_a_q | s1_b_q; cf_s = 1'b0; of_s = 1'b0; end
            OP_XOR: begin res_s = s1_a_q ^ s1_b_q; cf_s = 1'b0; of_s = 1'b0; end
            OP_NOT: begin res_s = ~s1_a_q;         cf_s = 1'b0; of_s = 1'b0; end
            OP_SHL: begin res_s = shl_s[WIDTH-1:0];         cf_s = shl_s[WIDTH];   of_s = 1'b0; end
            OP_SHR: begin res_s = shr_s[2*WIDTH-1:WIDTH];   cf_s = shr_s[WIDTH-1]; of_s = 1'b0; end
            OP_SAR: begin res_s = sar_s[2*WIDTH-1:WIDTH];   cf_s = sar_s[WIDTH-1]; of_s = 1'b0; end
            default: begin upd_s = 1'b0; wr_s = 1'b0; end
        endcase
        sf_s = res_s[WIDTH-1];
        zf_s = (res_s == {WIDTH{1'b0}});
    end

    // Next state for stage 1, the MUL FSM/iterator and the registered outputs; EN low holds everything.
    always_comb begin
        s1_valid_d = s1_valid_q; s1_op_d = s1_op_q; s1_a_d = s1_a_q; s1_b_d = s1_b_q;
        state_d = state_q; busy_d = busy_q; cnt_d = cnt_q;
        acc_d = acc_q; mcand_d = mcand_q; mplier_d = mplier_q;
        alu_out_d = alu_out_q; cf_d = cf_q; of_d = of_q; sf_d = sf_q; zf_d = zf_q;
        out_valid_d = out_valid_q;
        if (EN) begin
            s1_valid_d  = accept_s;
            out_valid_d = 1'b0;
            if (accept_s) begin
                s1_op_d = OPCODE; s1_a_d = A; s1_b_d = B;
            end else begin
                s1_op_d = s1_op_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (s1_valid_q && (s1_op_q == OP_MUL)) begin
                        state_d  = ST_MUL;
                        busy_d   = 1'b1;
                        cnt_d    = CNT_LOAD;
                        acc_d    = {(2*WIDTH){1'b0}};
                        mcand_d  = {{WIDTH{1'b0}}, s1_a_q};
                        mplier_d = s1_b_q;
                    end else if (s1_valid_q && upd_s) begin
                        out_valid_d = 1'b1;
                        cf_d = cf_s; of_d = of_s; sf_d = sf_s; zf_d = zf_s;
                        if (wr_s) begin
                            alu_out_d = res_s;
                        end else begin
                            alu_out_d = alu_out_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_d    = acc_nx_s;
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_d    = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d     = ST_IDLE;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b1;
                        alu_out_d   = acc_nx_s[WIDTH-1:0];
                        cf_d        = |acc_nx_s[2*WIDTH-1:WIDTH];
                        of_d        = |acc_nx_s[2*WIDTH-1:WIDTH];
                        sf_d        = acc_nx_s[WIDTH-1];
                        zf_d        = (acc_nx_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Register bank with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q <= 1'b0; s1_op_q <= 4'b0000;
            s1_a_q <= {WIDTH{1'b0}}; s1_b_q <= {WIDTH{1'b0}};
            state_q <= ST_IDLE; busy_q <= 1'b0; cnt_q <= {CNT_W{1'b0}};
            acc_q <= {(2*WIDTH){1'b0}}; mcand_q <= {(2*WIDTH){1'b0}}; mplier_q <= {WIDTH{1'b0}};
            alu_out_q <= {WIDTH{1'b0}};
            cf_q <= 1'b0; of_q <= 1'b0; sf_q <= 1'b0; zf_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_op_q <= s1_op_d; s1_a_q <= s1_a_d; s1_b_q <= s1_b_d;
            state_q <= state_d; busy_q <= busy_d; cnt_q <= cnt_d;
            acc_q <= acc_d; mcand_q <= mcand_d; mplier_q <= mplier_d;
            alu_out_q <= alu_out_d;
            cf_q <= cf_d; of_q <= of_d; sf_q <= sf_d; zf_q <= zf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = in_ready_s;
    assign BUSY      = busy_q;
    assign OUT_VALID = out_valid_q;
    assign CF = cf_q;
    assign OF = of_q;
    assign SF = sf_q;
    assign ZF = zf_q;
    assign ALU_OUT   = OE ? alu_out_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed cases plus random traffic checked against an
// op-queue reference model that computes results with plain integer arithmetic.
module tb_alu_pipe;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n, en, oe, in_valid;
    logic [3:0] opcode;
    logic [7:0] a, b;
    wire        in_ready, out_valid, cf, of, sf, zf, busy;
    wire  [7:0] alu_out;

    alu_pipe #(.WIDTH(W)) dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .OE(oe), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OPCODE(opcode), .A(a), .B(b), .OUT_VALID(out_valid), .ALU_OUT(alu_out),
        .CF(cf), .OF(of), .SF(sf), .ZF(zf), .BUSY(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] op; int a; int b; int rem; } op_t;
    op_t  pq[$];
    int   n_tests = 0, n_fail = 0;
    int   m_out = 0;
    logic m_cf = 1'b0, m_of = 1'b0, m_sf = 1'b0, m_zf = 1'b0, m_ov = 1'b0;
    logic acc_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        foreach (pq[i]) if (pq[i].op == 4'hC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        foreach (pq[i]) if (pq[i].op == 4'hC && pq[i].rem <= W) return 1'b1;
        return 1'b0;
    endfunction

    // Retire one op into the architectural model.
    task automatic model_apply(input op_t t);
        int r, n, c, sa;
        logic ncf, nof, upd;
        r = 0; ncf = 1'b0; nof = 1'b0; upd = 1'b1;
        n  = t.b % W;
        c  = ((t.op == 4'h1) || (t.op == 4'h2)) ? int'(m_cf) : 0;
        sa = (t.a >= 128) ? t.a - 256 : t.a;
        case (t.op)
            4'h1, 4'h3: begin
                r = t.a + t.b + c; ncf = (r > 255); r = r & 255;
                nof = ((t.a >= 128) == (t.b >= 128)) && ((r >= 128) != (t.a >= 128));
            end
            4'h2, 4'h4, 4'hD: begin
                r = t.a - t.b - c; ncf = (r < 0); r = r & 255;
                nof = ((t.a >= 128) != (t.b >= 128)) && ((r >= 128) != (t.a >= 128));
            end
            4'h5: r = t.a & t.b;
            4'h6: r = t.a | t.b;
            4'h7: r = t.a ^ t.b;
            4'h8: r = (~t.a) & 255;
            4'h9: begin r = (t.a << n) & 255; ncf = (n != 0) && (((t.a >> (8 - n)) & 1) != 0); end
            4'hA: begin r = t.a >> n;         ncf = (n != 0) && (((t.a >> (n - 1)) & 1) != 0); end
            4'hB: begin r = (sa >>> n) & 255; ncf = (n != 0) && (((t.a >> (n - 1)) & 1) != 0); end
            4'hC: begin r = t.a * t.b; ncf = (r > 255); nof = ncf; r = r & 255; end
            default: upd = 1'b0;
        endcase
        if (upd) begin
            if (t.op != 4'hD) m_out = r;
            m_cf = ncf; m_of = nof; m_sf = (r >= 128); m_zf = (r == 0); m_ov = 1'b1;
        end
    endtask

    task automatic model_edge(input logic e, input logic v, input logic [3:0] op,
                              input logic [7:0] av, input logic [7:0] bv, input logic rdy);
        op_t t;
        if (!e) return;
        m_ov = 1'b0;
        foreach (pq[i]) pq[i].rem--;
        if (pq.size() > 0 && pq[0].rem == 0) begin
            model_apply(pq[0]);
            void'(pq.pop_front());
        end
        if (v && rdy) begin
            t.op = op; t.a = int'(av); t.b = int'(bv);
            t.rem = (op == 4'hC) ? W + 1 : 1;
            pq.push_back(t);
        end
    endtask

    task automatic compare_all();
        check_eq("out_valid", out_valid, m_ov);
        check_eq("busy", busy, exp_busy());
        check_eq("cf", cf, m_cf);
        check_eq("of", of, m_of);
        check_eq("sf", sf, m_sf);
        check_eq("zf", zf, m_zf);
        if (oe) check_eq("alu_out", alu_out, m_out);
        else if (m_out != 0) check_eq("alu_out_hiz", alu_out !== 8'(m_out), 1'b1);
    endtask

    // One clock: drive after a falling edge, model the rising edge, compare at the next falling edge.
    task automatic cycle(input logic e, input logic v, input logic [3:0] op,
                         input logic [7:0] av, input logic [7:0] bv, output logic acc);
        logic rdy;
        en = e; in_valid = v; opcode = op; a = av; b = bv;
        #1;
        rdy = in_ready;
        check_eq("in_ready", rdy, exp_ready());
        acc = e && v && rdy;
        @(posedge clk);
        model_edge(e, v, op, av, bv, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic cyc(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
        cycle(1'b1, 1'b1, op, av, bv, acc_g);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, acc_g);
    endtask

    task automatic reset_mid_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_alu_out", alu_out, 8'h00);
        check_eq("rst_flags", {cf, of, sf, zf}, 4'b0000);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        pq.delete();
        m_out = 0; m_cf = 1'b0; m_of = 1'b0; m_sf = 1'b0; m_zf = 1'b0; m_ov = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, edges;
        logic mul_done;
        rst_n = 1'b0; en = 1'b0; oe = 1'b1; in_valid = 1'b0;
        opcode = 4'h0; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("reset_out", alu_out, 8'h00);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        cyc(4'h3, 8'h7F, 8'h01);
        check_eq("add_early_valid", out_valid, 1'b0);
        idle();
        check_eq("add7f_out", alu_out, 8'h80);
        check_eq("add7f_flags", {cf, of, sf, zf, out_valid}, 5'b01101);

        cyc(4'h3, 8'hFF, 8'h01);
        cyc(4'h1, 8'h00, 8'h00);
        check_eq("addff_out", alu_out, 8'h00);
        check_eq("addff_cf_zf", {cf, zf}, 2'b11);
        idle();
        check_eq("adc_out", alu_out, 8'h01);
        check_eq("adc_cf_zf", {cf, zf}, 2'b00);

        cyc(4'h4, 8'h10, 8'h20);
        cyc(4'hD, 8'h05, 8'h05);
        check_eq("sub_out", alu_out, 8'hF0);
        check_eq("sub_flags", {cf, of, sf}, 3'b101);
        idle();
        check_eq("cmp_out_held", alu_out, 8'hF0);
        check_eq("cmp_zf_cf", {zf, cf}, 2'b10);

        cyc(4'hB, 8'h81, 8'h01);
        cyc(4'h9, 8'h81, 8'h00);
        check_eq("sar_out", alu_out, 8'hC0);
        check_eq("sar_cf", cf, 1'b1);
        idle();
        check_eq("shl0_out", alu_out, 8'h81);
        check_eq("shl0_cf", cf, 1'b0);

        // MUL with a following ADD held on the input.
        cyc(4'hC, 8'h10, 8'h11);
        busy_cnt = 0; mul_done = 1'b0; acc_g = 1'b0;
        for (int i = 0; i < 20 && !acc_g; i++) begin
            cycle(1'b1, 1'b1, 4'h3, 8'h01, 8'h02, acc_g);
            if (busy) busy_cnt++;
            if (out_valid && !mul_done) begin
                mul_done = 1'b1;
                check_eq("mul_out", alu_out, 8'h10);
                check_eq("mul_cf_of", {cf, of}, 2'b11);
            end
        end
        check_eq("mul_done", mul_done, 1'b1);
        check_eq("mul_busy_cycles", busy_cnt, 8);
        check_eq("add_after_mul_accepted", acc_g, 1'b1);
        idle();
        check_eq("add_after_mul_out", alu_out, 8'h03);

        // EN low for 3 cycles in the middle of a MUL.
        cyc(4'hC, 8'h1B, 8'h0D);
        edges = 0;
        repeat (3) begin idle(); edges++; end
        repeat (3) begin cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, acc_g); edges++; end
        check_eq("frozen_busy", busy, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) begin idle(); edges++; end
        check_eq("mul_stall_edges", edges, 12);
        check_eq("mul_stall_out", alu_out, 8'h5F);
        check_eq("mul_stall_cf", cf, 1'b1);

        oe = 1'b0;
        idle();
        check_eq("oe_low_hiz", alu_out !== 8'h5F, 1'b1);
        check_eq("oe_low_flags", {cf, of, sf, zf}, 4'b1100);
        oe = 1'b1;
        idle();

        // Reset in the middle of a MUL; no result may follow.
        cyc(4'hC, 8'h03, 8'h05);
        idle(); idle();
        reset_mid_cycle();
        repeat (12) idle();

        for (int i = 0; i < 500; i++) begin
            oe = ($urandom_range(0, 15) != 0);
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), acc_g);
        end
        oe = 1'b1;
        repeat (12) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
